// File: rtl/hack_pkg.sv
// hack_pkg: shared Hack platform types and constants.
//   WORD_WIDTH : Hack data word width (16 bits)
//   word_t     : one Hack data word
//   addr8_t    : 3-bit word select within a RAM8, reused by ram64/ram512 address slicing
package hack_pkg;

    localparam int unsigned WORD_WIDTH = 16;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [2:0]            addr8_t;

endpackage

// File: rtl/ram8_word_reg.sv
// word_reg: WIDTH-bit storage register used for each RAM8 word.
// Also holds the two routing blocks of the RAM8 tier:
//   dmux8way : 1-to-8 demux of the load strobe (one or zero outputs active)
//   mux8way  : generic WIDTH-bit 8:1 read mux
// word_reg ports:
//   clk   in  1      rising-edge clock
//   reset in  1      synchronous, active-high; clears the word
//   load  in  1      write enable
//   in    in  WIDTH  write data
//   out   out WIDTH  stored word
module word_reg
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // Reset wins over load: a write on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (load) begin
            out <= in;
        end
    end

endmodule

// dmux8way ports:
//   in  in  1  strobe to route
//   sel in  3  destination select
//   out out 8  one-hot copy of in at position sel (all zero when in=0)
module dmux8way
    import hack_pkg::*;
(
    input  logic       in,
    input  addr8_t     sel,
    output logic [7:0] out
);

    always_comb begin
        out      = '0;
        out[sel] = in;
    end

endmodule

// mux8way ports:
//   data in  8 x WIDTH  candidate words
//   sel  in  3          word select
//   out  out WIDTH      data[sel]
module mux8way
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_WIDTH
) (
    input  logic [WIDTH-1:0] data [8],
    input  addr8_t           sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = data[sel];
    end

endmodule

// File: rtl/ram8.sv
// ram8: 8-word x WIDTH-bit register-file memory (Hack RAM8 tier).
// Write: on posedge clk with reset=0 and load=1, word[address] <= in.
// Read : out = word[address], combinational, no clock latency.
// Ports:
//   clk     in  1      single clock, rising edge
//   reset   in  1      synchronous, active-high; clears all 8 words, overrides load
//   in      in  WIDTH  write data
//   load    in  1      write enable for word[address]
//   address in  3      word select for both read and write
//   out     out WIDTH  read data
// Build option RAM8_WRITE_FWD_EN: when defined, a word being written
// (load=1, reset=0) shows the incoming value on out in the same cycle.
// Stored state is the same in both builds.
module ram8
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    output logic [WIDTH-1:0] out
);

    addr8_t           sel;
    logic [7:0]       load_strobe;
    logic [WIDTH-1:0] words [8];
    logic [WIDTH-1:0] read_word;

    assign sel = address;

    dmux8way u_load_decode (
        .in  (load),
        .sel (sel),
        .out (load_strobe)
    );

    for (genvar i = 0; i < 8; i++) begin : g_word
        word_reg #(.WIDTH(WIDTH)) u_word (
            .clk   (clk),
            .reset (reset),
            .load  (load_strobe[i]),
            .in    (in),
            .out   (words[i])
        );
    end

    mux8way #(.WIDTH(WIDTH)) u_read_mux (
        .data (words),
        .sel  (sel),
        .out  (read_word)
    );

`ifdef RAM8_WRITE_FWD_EN
    // Forwarding only bypasses the addressed word, and never on a reset
    // edge since that write is discarded.
    always_comb begin
        out = (load && !reset) ? in : read_word;
    end
`else
    always_comb begin
        out = read_word;
    end
`endif

endmodule

// File: tb/tb_ram8.sv
module tb_ram8;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic        load;
    logic [2:0]  address;
    logic [15:0] dout;

    int unsigned checks;
    int unsigned errors;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb [$];
    bit   stim_done;

    ram8 #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (din),
        .load    (load),
        .address (address),
        .out     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // X/Z address with load=1 is illegal stimulus.
    always @(negedge clk) begin
        assert (!(load === 1'b1 && $isunknown(address)))
            else $error("illegal address with load=1");
    end

    // Monitor: out is sampled mid-cycle, after inputs have settled.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (dout !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, dout, e.exp);
            end
        end
    end

    // One cycle of stimulus; optionally queue the value out must show this cycle.
    task automatic step(input logic rst, input logic ld, input logic [2:0] a,
                        input logic [15:0] d, input bit chk,
                        input logic [15:0] exp, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset   = rst;
        load    = ld;
        address = a;
        din     = d;
        if (chk) begin
            e.exp  = exp;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        step(1'b0, 1'b1, a, d, 1'b0, 16'h0, "");
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
        step(1'b0, 1'b0, a, 16'h0, 1'b1, exp, name);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0, "");
    endtask

    initial begin
        logic [15:0] walk_val;
        checks    = 0;
        errors    = 0;
        stim_done = 0;
        reset     = 1'b1;
        load      = 1'b0;
        address   = 3'd0;
        din       = 16'h0;

        // Power-up reset, then all words read zero.
        do_reset();
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, $sformatf("init_reset_a%0d", i));

        // 1: random preload then a single reset edge.
        for (int i = 0; i < 8; i++) wr(3'(i), 16'($urandom_range(1, 16'hFFFF)));
        do_reset();
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, $sformatf("t1_reset_a%0d", i));

        // 2: single write, neighbours untouched.
        wr(3'd3, 16'hBEEF);
        rd(3'd3, 16'hBEEF, "t2_readback_a3");
        for (int i = 0; i < 8; i++)
            if (i != 3) rd(3'(i), 16'h0000, $sformatf("t2_untouched_a%0d", i));

        // 3: value visible on out during the write cycle.
        wr(3'd5, 16'h1111);
        rd(3'd5, 16'h1111, "t3_preload_a5");
`ifdef RAM8_WRITE_FWD_EN
        step(1'b0, 1'b1, 3'd5, 16'h2222, 1'b1, 16'h2222, "t3_write_cycle_fwd");
`else
        step(1'b0, 1'b1, 3'd5, 16'h2222, 1'b1, 16'h1111, "t3_write_cycle_old");
`endif
        rd(3'd5, 16'h2222, "t3_after_edge");

        // 4: reset and load on the same edge; reset wins.
        wr(3'd7, 16'h1234);
        rd(3'd7, 16'h1234, "t4_preload_a7");
        step(1'b1, 1'b1, 3'd7, 16'hFFFF, 1'b0, 16'h0, "");
        rd(3'd7, 16'h0000, "t4_reset_beats_load");
        rd(3'd5, 16'h0000, "t4_reset_clears_a5");

        // 5: walk all addresses, read back in reverse, then idle with in toggling.
        for (int i = 0; i < 8; i++) begin
            walk_val = 16'h0101 * 16'(i);
            wr(3'(i), walk_val);
        end
        for (int i = 7; i >= 0; i--) begin
            walk_val = 16'h0101 * 16'(i);
            rd(3'(i), walk_val, $sformatf("t5_walk_a%0d", i));
        end
        for (int c = 0; c < 4; c++) begin
            walk_val = 16'h0101 * 16'(c * 2);
            step(1'b0, 1'b0, 3'(c * 2), (c % 2 == 0) ? 16'hFFFF : 16'h0000,
                 1'b1, walk_val, $sformatf("t5_idle_c%0d", c));
        end
        for (int i = 0; i < 8; i++) begin
            walk_val = 16'h0101 * 16'(i);
            rd(3'(i), walk_val, $sformatf("t5_hold_a%0d", i));
        end

        // 6: back-to-back writes to the same word; last one sticks.
        do_reset();
        wr(3'd2, 16'hAAAA);
        wr(3'd2, 16'h5555);
        rd(3'd2, 16'h5555, "t6_last_write_wins");
        rd(3'd6, 16'h0000, "t6_a6_untouched");

        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0, "");
        stim_done = 1;
    end

    initial begin
        int unsigned waited;
        waited = 0;
        while (!(stim_done && sb.size() == 0) && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending expected 0 pending", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
